// File: rtl/fft_power_averager.sv
// Per-bin FFT power |X[k]|^2 accumulated over 2^LOG2_AVG frames; the last frame of each window
// streams the averaged spectrum out one bin per cycle, three cycles after the matching input.
module fft_power_averager #(
  parameter int LOG2_NFFT = 10,
  parameter int LOG2_AVG  = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        dv_in,
  input  logic signed [15:0]          xk_re_in,
  input  logic signed [15:0]          xk_im_in,
  output logic                        pwr_valid,
  output logic [LOG2_NFFT-1:0]        pwr_bin,
  output logic [31:0]                 pwr_avg,
  output logic                        frame_done
);

  localparam int DATA_W = 16;
  localparam int ACC_W  = 32 + LOG2_AVG;
  localparam int NFFT   = 1 << LOG2_NFFT;
  localparam int FRM_W  = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [FRM_W-1:0]     FRM_LAST = FRM_W'((1 << LOG2_AVG) - 1);
  localparam logic [LOG2_NFFT-1:0] BIN_LAST = '1;

  // Square kept to 31 bits: x*x <= 2^30, so the product modulo 2^31 is exact.
  function automatic logic [30:0] sq(input logic signed [DATA_W-1:0] x);
    return 31'(x) * 31'(x);
  endfunction

  function automatic logic [31:0] avg_shift(input logic [ACC_W-1:0] acc);
    return 32'(acc >> LOG2_AVG);
  endfunction

  logic [LOG2_NFFT-1:0] bin_cnt_q, bin_cnt_d;
  logic [FRM_W-1:0]     frm_cnt_q, frm_cnt_d;
  logic                 vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d, vld_p3_q, vld_p3_d;
  logic [30:0]          re_sq_p1_q, re_sq_p1_d, im_sq_p1_q, im_sq_p1_d;
  logic [LOG2_NFFT-1:0] bin_p1_q, bin_p1_d, bin_p2_q, bin_p2_d, bin_p3_q, bin_p3_d;
  logic                 first_p1_q, first_p1_d, first_p2_q, first_p2_d;
  logic                 last_p1_q, last_p1_d, last_p2_q, last_p2_d, last_p3_q, last_p3_d;
  logic [31:0]          pwr_p2_q, pwr_p2_d;
  logic [ACC_W-1:0]     rd_p2_q, rd_p2_d, acc_p3_q, acc_p3_d;
  logic                 pwr_valid_q, pwr_valid_d, frame_done_q, frame_done_d;
  logic [LOG2_NFFT-1:0] pwr_bin_q, pwr_bin_d;
  logic [31:0]          pwr_avg_q, pwr_avg_d;
  logic                 acc_we;
  logic [ACC_W-1:0]     acc_mem [NFFT];

  always_comb begin
    bin_cnt_d = bin_cnt_q;
    frm_cnt_d = frm_cnt_q;
    if (clear) begin
      bin_cnt_d = '0;
      frm_cnt_d = '0;
    end else if (dv_in) begin
      bin_cnt_d = bin_cnt_q + 1'b1;
      if (bin_cnt_q == BIN_LAST)
        frm_cnt_d = (frm_cnt_q == FRM_LAST) ? '0 : frm_cnt_q + 1'b1;
    end

    // Stage 1: squares, bin tag and window-position flags
    vld_p1_d   = dv_in & ~clear;
    re_sq_p1_d = sq(xk_re_in);
    im_sq_p1_d = sq(xk_im_in);
    bin_p1_d   = bin_cnt_q;
    first_p1_d = (frm_cnt_q == '0);
    last_p1_d  = (frm_cnt_q == FRM_LAST);

    // Stage 2: power sum and accumulator read
    vld_p2_d   = vld_p1_q & ~clear;
    pwr_p2_d   = 32'(re_sq_p1_q) + 32'(im_sq_p1_q);
    rd_p2_d    = acc_mem[bin_p1_q];
    bin_p2_d   = bin_p1_q;
    first_p2_d = first_p1_q;
    last_p2_d  = last_p1_q;

    // Stage 3: accumulate (first frame overwrites stale contents) and write back
    vld_p3_d  = vld_p2_q & ~clear;
    acc_p3_d  = first_p2_q ? ACC_W'(pwr_p2_q) : rd_p2_q + ACC_W'(pwr_p2_q);
    bin_p3_d  = bin_p2_q;
    last_p3_d = last_p2_q;
    acc_we    = vld_p2_q;

    // Output: only the last frame of a window is presented
    pwr_valid_d  = vld_p3_q & last_p3_q & ~clear;
    frame_done_d = pwr_valid_d & (bin_p3_q == BIN_LAST);
    pwr_bin_d    = pwr_valid_d ? bin_p3_q : pwr_bin_q;
    pwr_avg_d    = pwr_valid_d ? avg_shift(acc_p3_q) : pwr_avg_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      bin_cnt_q    <= '0;
      frm_cnt_q    <= '0;
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      vld_p3_q     <= 1'b0;
      pwr_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      pwr_bin_q    <= '0;
      pwr_avg_q    <= '0;
    end else begin
      bin_cnt_q    <= bin_cnt_d;
      frm_cnt_q    <= frm_cnt_d;
      vld_p1_q     <= vld_p1_d;
      vld_p2_q     <= vld_p2_d;
      vld_p3_q     <= vld_p3_d;
      pwr_valid_q  <= pwr_valid_d;
      frame_done_q <= frame_done_d;
      pwr_bin_q    <= pwr_bin_d;
      pwr_avg_q    <= pwr_avg_d;
    end
  end

  always_ff @(posedge clock) begin
    re_sq_p1_q <= re_sq_p1_d;
    im_sq_p1_q <= im_sq_p1_d;
    bin_p1_q   <= bin_p1_d;
    first_p1_q <= first_p1_d;
    last_p1_q  <= last_p1_d;
    pwr_p2_q   <= pwr_p2_d;
    rd_p2_q    <= rd_p2_d;
    bin_p2_q   <= bin_p2_d;
    first_p2_q <= first_p2_d;
    last_p2_q  <= last_p2_d;
    acc_p3_q   <= acc_p3_d;
    bin_p3_q   <= bin_p3_d;
    last_p3_q  <= last_p3_d;
  end

  // Consecutive samples never share a bin, so the write here cannot race a pending read.
  always_ff @(posedge clock) begin
    if (acc_we)
      acc_mem[bin_p2_q] <= acc_p3_d;
  end

  assign pwr_valid  = pwr_valid_q;
  assign pwr_bin    = pwr_bin_q;
  assign pwr_avg    = pwr_avg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fft_power_averager.sv
// Bench for fft_power_averager (16 bins, 4-frame average): a driver pushes expected outputs,
// a negedge monitor pops and compares bin, value, frame_done and arrival cycle.
module tb_fft_power_averager;
  localparam int LN = 4;
  localparam int LA = 2;
  localparam int N  = 16;
  localparam int A  = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  logic dv_in = 1'b0;
  logic signed [15:0] xk_re_in = '0;
  logic signed [15:0] xk_im_in = '0;
  logic pwr_valid, frame_done;
  logic [LN-1:0] pwr_bin;
  logic [31:0] pwr_avg;

  always #5 clock = ~clock;

  fft_power_averager #(.LOG2_NFFT(LN), .LOG2_AVG(LA)) dut (
    .clock(clock), .reset(reset), .clear(clear), .dv_in(dv_in),
    .xk_re_in(xk_re_in), .xk_im_in(xk_im_in),
    .pwr_valid(pwr_valid), .pwr_bin(pwr_bin), .pwr_avg(pwr_avg), .frame_done(frame_done)
  );

  typedef struct {
    int     bin;
    longint avg;
    bit     fd;
    int     cyc;
  } exp_t;

  exp_t   sb[$];
  exp_t   e_m;
  int     checks = 0, errors = 0, cyc = 0, n_out = 0, n0 = 0;
  longint obs_avg[N];
  longint msum[N];
  int     mbin = 0, mfrm = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_output: bin %0d due at cycle %0d, none by cycle %0d", sb[0].bin, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    if (pwr_valid === 1'b1) begin
      n_out++;
      obs_avg[pwr_bin] = pwr_avg;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: bin %0d avg %0d at cycle %0d, want no output", pwr_bin, pwr_avg, cyc);
      end else begin
        e_m = sb.pop_front();
        if (pwr_bin != e_m.bin || pwr_avg != e_m.avg || frame_done != e_m.fd || cyc != e_m.cyc) begin
          errors++;
          $display("FAIL output: got bin %0d avg %0d fd %0b cyc %0d, want bin %0d avg %0d fd %0b cyc %0d",
                   pwr_bin, pwr_avg, frame_done, cyc, e_m.bin, e_m.avg, e_m.fd, e_m.cyc);
        end
      end
    end else if (frame_done === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL frame_done_alone: got frame_done 1 with pwr_valid %0b, want 0", pwr_valid);
    end
  end

  task automatic send(input logic signed [15:0] re, input logic signed [15:0] im);
    longint p;
    @(negedge clock);
    reset = 1'b1; clear = 1'b0; dv_in = 1'b1;
    xk_re_in = re; xk_im_in = im;
    p = longint'(re) * re + longint'(im) * im;
    if (mfrm == 0) msum[mbin] = p;
    else msum[mbin] += p;
    if (mfrm == A - 1) sb.push_back('{mbin, msum[mbin] >> LA, (mbin == N - 1), cyc + 4});
    mbin++;
    if (mbin == N) begin
      mbin = 0;
      mfrm = (mfrm + 1) % A;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      reset = 1'b1; clear = 1'b0; dv_in = 1'b0;
    end
  endtask

  // Abort the window with clear or reset, coincident with a valid sample that must be discarded.
  task automatic kill(input bit is_reset);
    @(negedge clock);
    dv_in = 1'b1; xk_re_in = 16'sd7; xk_im_in = 16'sd7;
    if (is_reset) reset = 1'b0;
    else clear = 1'b1;
    mbin = 0;
    mfrm = 0;
    while (sb.size() > 0 && sb[$].cyc >= cyc + 1) void'(sb.pop_back());
  endtask

  task automatic frames(input int nf, input logic signed [15:0] re, input logic signed [15:0] im);
    for (int f = 0; f < nf; f++)
      for (int b = 0; b < N; b++) send(re, im);
  endtask

  initial begin
    // 1: reset held with dv toggling
    repeat (3) begin
      @(negedge clock);
      dv_in = ~dv_in; xk_re_in = 16'sd100; xk_im_in = 16'sd50;
    end
    chk("rst_pwr_valid", pwr_valid, 0);
    chk("rst_pwr_bin", pwr_bin, 0);
    chk("rst_pwr_avg", pwr_avg, 0);
    chk("rst_frame_done", frame_done, 0);
    idle(6);

    // 2: 3+4j everywhere
    n0 = n_out;
    frames(4, 16'sd3, 16'sd4);
    idle(5);
    chk("t2_count", n_out - n0, 16);
    chk("t2_bin0", obs_avg[0], 25);
    chk("t2_bin15", obs_avg[15], 25);

    // 3: full-scale negative on both rails
    n0 = n_out;
    frames(4, -16'sd32768, -16'sd32768);
    idle(5);
    chk("t3_count", n_out - n0, 16);
    chk("t3_bin7", obs_avg[7], 64'h8000_0000);

    // 4: bin 5 ramps 1..4 over the window
    for (int f = 0; f < A; f++)
      for (int b = 0; b < N; b++)
        if (b == 5) send(16'(f + 1), 16'sd0);
        else send(16'sd3, 16'sd4);
    idle(5);
    chk("t4_bin5", obs_avg[5], 7);
    chk("t4_bin6", obs_avg[6], 25);

    // 5: gapped input, two windows
    n0 = n_out;
    for (int i = 0; i < A * N; i++) begin
      send(16'sd10, 16'sd0);
      idle(2);
    end
    idle(3);
    chk("t5_count_w1", n_out - n0, 16);
    chk("t5_bin2_w1", obs_avg[2], 100);
    foreach (obs_avg[i]) obs_avg[i] = 0;
    n0 = n_out;
    for (int i = 0; i < A * N; i++) begin
      send(16'sd10, 16'sd0);
      idle(2);
    end
    idle(3);
    chk("t5_count_w2", n_out - n0, 16);
    chk("t5_bin2_w2", obs_avg[2], 100);

    // 6a: clear at frame 2 bin 7
    frames(2, 16'sd1, 16'sd1);
    for (int b = 0; b < 7; b++) send(16'sd1, 16'sd1);
    kill(1'b0);
    idle(1);
    chk("clr_pwr_valid", pwr_valid, 0);
    chk("clr_hold_bin", pwr_bin, 15);
    chk("clr_hold_avg", pwr_avg, 100);
    n0 = n_out;
    frames(3, 16'sd1, 16'sd1);
    idle(5);
    chk("clr_no_early_output", n_out - n0, 0);
    frames(1, 16'sd1, 16'sd1);
    idle(5);
    chk("clr_count", n_out - n0, 16);
    chk("clr_bin0", obs_avg[0], 2);

    // 6b: reset at frame 2 bin 7
    frames(2, 16'sd2, 16'sd0);
    for (int b = 0; b < 7; b++) send(16'sd2, 16'sd0);
    kill(1'b1);
    idle(1);
    chk("mrst_pwr_bin", pwr_bin, 0);
    chk("mrst_pwr_avg", pwr_avg, 0);
    n0 = n_out;
    frames(3, 16'sd2, 16'sd0);
    idle(5);
    chk("mrst_no_early_output", n_out - n0, 0);
    frames(1, 16'sd2, 16'sd0);
    idle(5);
    chk("mrst_count", n_out - n0, 16);
    chk("mrst_bin0", obs_avg[0], 4);

    // 6c: clear during the output frame drops samples still in the pipeline
    n0 = n_out;
    frames(3, 16'sd3, 16'sd4);
    for (int b = 0; b < 7; b++) send(16'sd3, 16'sd4);
    kill(1'b0);
    idle(5);
    chk("clr_inflight_count", n_out - n0, 4);
    chk("clr_inflight_bin", pwr_bin, 3);
    n0 = n_out;
    frames(4, 16'sd3, 16'sd4);
    idle(5);
    chk("clr_inflight_recover", n_out - n0, 16);

    for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
    chk("drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
